// File: rtl/sample_pkg.sv
// Shared sizing and state encoding for the sonar sample sequencer.
package sample_pkg;

    localparam int N_FEAT = 60;
    localparam int W      = 16;
    localparam int UZ_W   = N_FEAT * W;
    localparam int IDX_W  = $clog2(N_FEAT);
    // Wide enough for the legal settle range 1..15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_sekvencer.sv
// Streams 60 features into the classifier input vector, waits for the net to settle,
// then hands the captured outputs and class decision downstream one sample at a time.
module sample_sekvencer
    import sample_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    input  logic            s_last,
    output logic [UZ_W-1:0] uzorak,
    input  logic [W-1:0]    izlaz_1,
    input  logic [W-1:0]    izlaz_2,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_izlaz_1,
    output logic [W-1:0]    m_izlaz_2,
    output logic            m_razred,
    output logic            okvir_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             beat;

    assign beat = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            // NOTE: the sample vector is cleared on reset so an aborted load leaves no residue.
            uzorak    <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_izlaz_1 <= '0;
            m_izlaz_2 <= '0;
            m_razred  <= 1'b0;
            okvir_err <= 1'b0;
        end else begin
            okvir_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (beat) begin
                        uzorak[idx*W +: W] <= s_data;
                        if (s_last && idx == LAST_IDX) begin
                            state   <= SETTLE;
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            idx     <= '0;
                        end else if (s_last || idx == LAST_IDX) begin
                            // Early or missing last: drop the sample and resync on slot 0.
                            okvir_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_END) begin
                        m_izlaz_1 <= izlaz_1;
                        m_izlaz_2 <= izlaz_2;
                        m_razred  <= (izlaz_1 > izlaz_2);
                        m_valid   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_sekvencer.sv
// Directed bench for sample_sekvencer with a scripted stand-in for the classifier net.
module tb_sample_sekvencer;
    import sample_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            s_last;
    logic [UZ_W-1:0] uzorak;
    logic [W-1:0]    izlaz_1;
    logic [W-1:0]    izlaz_2;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_izlaz_1;
    logic [W-1:0]    m_izlaz_2;
    logic            m_razred;
    logic            okvir_err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_slot [N_FEAT];

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] i1;
        logic [W-1:0] i2;
        logic         exp_r;
        bit           gaps;
        int           hold;
    } vec_t;

    vec_t vecs [6];

    sample_sekvencer #(.SETTLE_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .uzorak    (uzorak),
        .izlaz_1   (izlaz_1),
        .izlaz_2   (izlaz_2),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_izlaz_1 (m_izlaz_1),
        .m_izlaz_2 (m_izlaz_2),
        .m_razred  (m_razred),
        .okvir_err (okvir_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bad_slots();
        int n = 0;
        for (int k = 0; k < N_FEAT; k++)
            if (uzorak[k*W +: W] !== exp_slot[k]) n++;
        return n;
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < N_FEAT; k++) exp_slot[k] = '0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last, input bit gaps);
        if (gaps) begin
            s_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(1, 0) == 1) tick();
                else break;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_sample(input vec_t v, input string tag);
        logic [W-1:0] d;
        izlaz_1 = 16'hAAAA;
        izlaz_2 = 16'h5555;
        for (int k = 0; k < N_FEAT; k++) begin
            d = v.base + W'(k + 1);
            exp_slot[k] = d;
            check({tag, "_s_ready_load"}, s_ready, 1);
            send_beat(d, k == N_FEAT - 1, v.gaps);
        end
        izlaz_1 = v.i1;
        izlaz_2 = v.i2;
        check({tag, "_s_ready_settle"}, s_ready, 0);
        check({tag, "_m_valid_e0"}, m_valid, 0);
        tick();
        check({tag, "_m_valid_e1"}, m_valid, 0);
        tick();
        check({tag, "_m_valid_e2"}, m_valid, 1);
        check({tag, "_m_izlaz_1"}, m_izlaz_1, v.i1);
        check({tag, "_m_izlaz_2"}, m_izlaz_2, v.i2);
        check({tag, "_m_razred"}, m_razred, v.exp_r);
        check({tag, "_uzorak_bad_slots"}, bad_slots(), 0);
        // The net output may move freely once captured.
        izlaz_1 = 16'hDEAD;
        izlaz_2 = 16'hBEEF;
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        for (int c = 0; c < v.hold; c++) begin
            tick();
            check({tag, "_hold_m_valid"}, m_valid, 1);
            check({tag, "_hold_s_ready"}, s_ready, 0);
            check({tag, "_hold_m_izlaz_1"}, m_izlaz_1, v.i1);
            check({tag, "_hold_m_izlaz_2"}, m_izlaz_2, v.i2);
            check({tag, "_hold_m_razred"}, m_razred, v.exp_r);
        end
        s_valid = 1'b0;
        check({tag, "_hold_uzorak"}, bad_slots(), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check({tag, "_ack_m_valid"}, m_valid, 0);
        check({tag, "_ack_s_ready"}, s_ready, 1);
        check({tag, "_ack_m_izlaz_1_kept"}, m_izlaz_1, v.i1);
    endtask

    initial begin
        logic [W-1:0] slot_val;
        bit           saw_valid;

        vecs[0] = '{16'h0000, 16'h4000, 16'h1000, 1'b1, 1'b0, 10};
        vecs[1] = '{16'h0100, 16'h1000, 16'h4000, 1'b0, 1'b0, 0};
        vecs[2] = '{16'hFF00, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 2};
        vecs[3] = '{16'h2000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0};
        vecs[4] = '{16'h3000, 16'h8000, 16'h8000, 1'b0, 1'b1, 0};
        vecs[5] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        izlaz_1 = '0;
        izlaz_2 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_exp();
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_okvir_err", okvir_err, 0);
        check("rst_m_izlaz_1", m_izlaz_1, 0);
        check("rst_m_izlaz_2", m_izlaz_2, 0);
        check("rst_m_razred", m_razred, 0);
        check("rst_uzorak", bad_slots(), 0);

        for (int i = 0; i < 6; i++)
            run_sample(vecs[i], $sformatf("vec%0d", i));

        // Early last on the 30th beat.
        for (int k = 0; k < 30; k++)
            send_beat(16'h0A00 + W'(k), k == 29, 1'b0);
        check("early_okvir_err_pulse", okvir_err, 1);
        check("early_s_ready", s_ready, 1);
        tick();
        check("early_okvir_err_clear", okvir_err, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (m_valid) saw_valid = 1'b1;
            tick();
        end
        check("early_no_m_valid", saw_valid, 0);
        run_sample(vecs[1], "after_early");

        // Missing last: 60 beats without s_last, then one more beat lands in slot 0.
        for (int k = 0; k < N_FEAT; k++) begin
            send_beat(16'h0B00 + W'(k), 1'b0, 1'b0);
            if (k < N_FEAT - 1) check("missing_no_err_early", okvir_err, 0);
        end
        check("missing_okvir_err_pulse", okvir_err, 1);
        check("missing_m_valid", m_valid, 0);
        send_beat(16'h7777, 1'b0, 1'b0);
        check("missing_okvir_err_clear", okvir_err, 0);
        slot_val = uzorak[15:0];
        check("missing_beat61_slot0", slot_val, 16'h7777);
        slot_val = uzorak[31:16];
        check("missing_slot1_untouched", slot_val, 16'h0B01);
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (m_valid) saw_valid = 1'b1;
            tick();
        end
        check("missing_no_m_valid", saw_valid, 0);

        // Reset mid-load after 25 beats.
        do_reset();
        for (int k = 0; k < 25; k++)
            send_beat(16'h0500 + W'(k), 1'b0, 1'b0);
        do_reset();
        clear_exp();
        check("midrst_uzorak", bad_slots(), 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_okvir_err", okvir_err, 0);
        run_sample(vecs[0], "after_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_sekvencer.md
Name: sample_sekvencer

Overview:
Streaming front/back-end for the combinational mine/rock classifier. Accepts one sonar sample as 60 serial 16-bit features over a valid/ready stream and assembles them into the 960-bit uzorak vector that drives the network. It waits a fixed settle time, captures the two 16-bit network outputs, and presents them with a class decision on an output valid/ready handshake. Turns the purely combinational net into a sample-at-a-time pipelined unit.

Parameters:
N_FEAT, 60, features per sample
W, 16, bits per feature and per network output
SETTLE_CYC, 2, clock cycles allowed for combinational net to settle (legal range 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
s_valid  in  1  input feature valid
s_ready  out  1  input feature ready
s_data  in  W  feature value
s_last  in  1  marks final feature of a sample
uzorak  out  N_FEAT*W  assembled sample to net; feature k at [16k+15:16k]
izlaz_1  in  W  net output 1
izlaz_2  in  W  net output 2
m_valid  out  1  result valid
m_ready  in  1  result accepted downstream
m_izlaz_1  out  W  captured izlaz_1
m_izlaz_2  out  W  captured izlaz_2
m_razred  out  1  1 when izlaz_1 > izlaz_2 (unsigned), else 0
okvir_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (rst_n=0 at an edge): state LOAD, feature index 0, uzorak=0, m_valid=0, m_izlaz_1/2=0, m_razred=0, okvir_err=0, settle counter 0. s_ready=1 in the cycle after reset releases. Reset mid-load or mid-result discards everything.
- States: LOAD, SETTLE, DONE.
- LOAD: s_ready=1. Beat = s_valid&s_ready at an edge; writes s_data into slot idx, idx++. First beat of a sample is slot 0. Gaps in s_valid allowed, no timeout.
  - Beat at idx=N_FEAT-1 with s_last=1: go to SETTLE, idx<=0.
  - Beat with s_last=1 at idx<N_FEAT-1 (early last), or beat at idx=N_FEAT-1 with s_last=0 (missing last): okvir_err=1 for exactly one cycle; sample dropped, idx<=0, stay LOAD. uzorak contents are not cleared (don't-care); no m_valid is produced.
- SETTLE: s_ready=0. uzorak is held. Counter runs SETTLE_CYC cycles. On the edge ending the last settle cycle, capture izlaz_1, izlaz_2, and the compare into the m_* registers; go to DONE.
- Timing: last beat accepted at edge E0 -> m_valid=1 after edge E0+SETTLE_CYC.
- DONE: m_valid=1. s_ready=0. m_* and uzorak are stable while m_valid=1 and m_ready=0, for any duration. On edge with m_ready=1: m_valid<=0, go to LOAD. m_* keep their last values after the handshake.
- m_valid is never asserted in the same cycle as s_ready. Samples do not overlap: at most one sample in flight.
- Compare is unsigned 16-bit. On a tie, m_razred=0.
- uzorak slots update per beat during LOAD. The net output is only sampled in SETTLE.

Decomposition:
- Package sample_pkg: N_FEAT, W, derived UZ_W=N_FEAT*W, IDX_W=$clog2(N_FEAT), state enum {LOAD,SETTLE,DONE}.
- No sub-module warranted. Single module: FSM, index counter, settle counter, slot-write decode, result registers.
- Bench instantiates sample_sekvencer plus the real classifier (or a stub net with scripted outputs) on uzorak/izlaz_1/izlaz_2.

Test Plan:
- Basic: reset, send features k+1 (k=0..59), s_last on 60th; stub returns izlaz_1=0x4000, izlaz_2=0x1000. Required: uzorak[15:0]=0x0001 and [959:944]=0x003C; m_valid rises 2 cycles after last beat with m_izlaz_1=0x4000, m_izlaz_2=0x1000, m_razred=1.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid. Required: m_valid and m_* stable, s_ready=0 throughout; m_ready=1 -> m_valid=0 next cycle, s_ready=1.
- Early last: s_last on beat 30. Required: okvir_err high exactly 1 cycle, no m_valid; next clean 60-beat sample gives a correct result.
- Missing last: 60 beats with s_last=0. Required: okvir_err pulse on 60th beat, no m_valid; the 61st beat is accepted into slot 0.
- Tie and gaps: random s_valid gaps (~50% duty); stub izlaz_1=izlaz_2=0x8000. Required: all 60 slots correct, m_razred=0.
- Reset mid-load: assert rst_n=0 for 1 cycle after beat 25. Required: uzorak=0 and m_valid=0 next cycle; a fresh 60-beat sample completes correctly with no residue from the aborted sample.
